// File: rtl/gpio_input_filter_pkg.sv
// Shared definitions for the GPIO input conditioning block: debounce state
// encodings, default parameters and the sticky-flag update rule.
package gpio_input_filter_pkg;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

    localparam int DEFAULT_WIDTH           = 6;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    // A set arriving together with a clear wins, so an edge is never lost.
    function automatic logic sticky_next(input logic flag, input logic set, input logic clr);
        return set | (flag & ~clr);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: synchronizer chain, debounce counter/state machine,
// filtered level and its one-cycle-delayed copy for edge detection.
module gpio_debounce_bit
    import gpio_input_filter_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic enable_i,
    output logic filtered_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;
    db_state_e              state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   filtered_q;
    logic                   prev_q;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // The synchronizer keeps shifting while the filter is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DB_IDLE;
            cnt_q      <= '0;
            filtered_q <= 1'b0;
        end else if (!enable_i) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DB_IDLE: begin
                    if (sync_q != filtered_q) begin
                        state_q <= DB_COUNT;
                        cnt_q   <= CNT_WIDTH'(1);
                    end
                end
                DB_COUNT: begin
                    if (sync_q == filtered_q) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        filtered_q <= sync_q;
                        state_q    <= DB_IDLE;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filtered_q;
        end
    end

    assign filtered_o = filtered_q;
    assign rise_o     = filtered_q & ~prev_q;
    assign fall_o     = ~filtered_q & prev_q;

endmodule

// File: rtl/gpio_input_filter.sv
// Conditions raw GPIO pads: per-bit synchronize and debounce, then edge
// pulses, sticky rise/fall flags and a maskable level interrupt.
module gpio_input_filter
    import gpio_input_filter_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] filtered_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] rise_flags_o,
    output logic [WIDTH-1:0] fall_flags_o,
    input  logic [WIDTH-1:0] flags_clear_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic             irq_o
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_flags_q;
    logic [WIDTH-1:0] rise_flags_d;
    logic [WIDTH-1:0] fall_flags_q;
    logic [WIDTH-1:0] fall_flags_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .pin_i      (pins_i[i]),
            .enable_i   (enable_i),
            .filtered_o (filtered_o[i]),
            .rise_o     (rise[i]),
            .fall_o     (fall[i])
        );
    end

    // A clear strobe drops both flags of its bit unless that bit has a new edge.
    always_comb begin
        rise_flags_d = '0;
        fall_flags_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_flags_d[i] = sticky_next(rise_flags_q[i], rise[i], flags_clear_i[i]);
            fall_flags_d[i] = sticky_next(fall_flags_q[i], fall[i], flags_clear_i[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_flags_q <= '0;
            fall_flags_q <= '0;
        end else begin
            rise_flags_q <= rise_flags_d;
            fall_flags_q <= fall_flags_d;
        end
    end

    assign rise_o       = rise;
    assign fall_o       = fall;
    assign rise_flags_o = rise_flags_q;
    assign fall_flags_o = fall_flags_q;
    assign irq_o        = |((rise_flags_q | fall_flags_q) & irq_mask_i);

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed bench for gpio_input_filter (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// expected edge events are queued by the stimulus and checked by a monitor.
module tb_gpio_input_filter;

    localparam int WIDTH = 2;
    localparam int LAT   = 7;

    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] filt;
    } edge_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] pins_i = '0;
    logic             enable_i = 1'b1;
    logic [WIDTH-1:0] filtered_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] rise_flags_o;
    logic [WIDTH-1:0] fall_flags_o;
    logic [WIDTH-1:0] flags_clear_i = '0;
    logic [WIDTH-1:0] irq_mask_i = '0;
    logic             irq_o;

    int    cycle = 0;
    int    checks = 0;
    int    errors = 0;
    edge_t expQ[$];
    edge_t monE;

    gpio_input_filter #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pins_i        (pins_i),
        .enable_i      (enable_i),
        .filtered_o    (filtered_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .rise_flags_o  (rise_flags_o),
        .fall_flags_o  (fall_flags_o),
        .flags_clear_i (flags_clear_i),
        .irq_mask_i    (irq_mask_i),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue an edge that must appear `delay` cycles after the current negedge.
    task automatic expectEdge(input int delay, input logic [1:0] r, input logic [1:0] f,
                              input logic [1:0] filt);
        edge_t e;
        e.cyc  = cycle + delay;
        e.rise = r;
        e.fall = f;
        e.filt = filt;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] pins, input int holdCycles);
        pins_i = pins;
        tick(holdCycles);
    endtask

    always @(negedge clk) begin
        if (!reset && ((rise_o | fall_o) !== 2'b00)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_edge: got rise=%b fall=%b, expected none (cycle %0d)",
                         rise_o, fall_o, cycle);
            end else begin
                monE = expQ.pop_front();
                checkOutput("edge_cycle", cycle, monE.cyc);
                checkOutput("edge_rise", int'(rise_o), int'(monE.rise));
                checkOutput("edge_fall", int'(fall_o), int'(monE.fall));
                checkOutput("edge_filtered", int'(filtered_o), int'(monE.filt));
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(3);
        checkOutput("reset_filtered", int'(filtered_o), 0);
        checkOutput("reset_rise", int'(rise_o), 0);
        checkOutput("reset_fall", int'(fall_o), 0);
        checkOutput("reset_rise_flags", int'(rise_flags_o), 0);
        checkOutput("reset_fall_flags", int'(fall_flags_o), 0);
        checkOutput("reset_irq", int'(irq_o), 0);
        reset = 1'b0;
        tick(2);

        // Clean step on bit 0
        expectEdge(LAT, 2'b01, 2'b00, 2'b01);
        applyStimulus(2'b01, LAT + 1);
        checkOutput("step_rise_pulse_gone", int'(rise_o), 0);
        checkOutput("step_rise_flags", int'(rise_flags_o), 1);
        checkOutput("step_filtered", int'(filtered_o), 1);

        // Back to 0, then clear all flags
        expectEdge(LAT, 2'b00, 2'b01, 2'b00);
        applyStimulus(2'b00, LAT + 2);
        checkOutput("fall_flags_bit0", int'(fall_flags_o), 1);
        flags_clear_i = 2'b11;
        tick(1);
        flags_clear_i = 2'b00;
        checkOutput("clear_rise_flags", int'(rise_flags_o), 0);
        checkOutput("clear_fall_flags", int'(fall_flags_o), 0);

        // Bounce on bit 0, then settle high
        applyStimulus(2'b01, 2);
        applyStimulus(2'b00, 2);
        applyStimulus(2'b01, 2);
        applyStimulus(2'b00, 2);
        checkOutput("bounce_filtered", int'(filtered_o), 0);
        expectEdge(LAT, 2'b01, 2'b00, 2'b01);
        applyStimulus(2'b01, LAT + 1);
        checkOutput("bounce_rise_flags", int'(rise_flags_o), 1);

        // Set/clear collision on bit 1
        expectEdge(LAT, 2'b10, 2'b00, 2'b11);
        applyStimulus(2'b11, LAT + 1);
        expectEdge(LAT, 2'b00, 2'b10, 2'b01);
        applyStimulus(2'b01, LAT);
        flags_clear_i = 2'b10;
        tick(1);
        flags_clear_i = 2'b00;
        checkOutput("collision_fall_flags", int'(fall_flags_o), 2);
        checkOutput("collision_rise_flags", int'(rise_flags_o), 1);
        flags_clear_i = 2'b10;
        tick(1);
        flags_clear_i = 2'b00;
        checkOutput("plain_clear_fall_flags", int'(fall_flags_o), 0);
        checkOutput("plain_clear_rise_flags", int'(rise_flags_o), 1);

        // Interrupt masking
        irq_mask_i = 2'b10;
        #1;
        checkOutput("irq_masked", int'(irq_o), 0);
        irq_mask_i = 2'b11;
        #1;
        checkOutput("irq_unmasked", int'(irq_o), 1);
        flags_clear_i = 2'b01;
        tick(1);
        flags_clear_i = 2'b00;
        checkOutput("irq_after_clear", int'(irq_o), 0);
        checkOutput("irq_clear_rise_flags", int'(rise_flags_o), 0);

        // Freeze the filter mid-count (cnt=3), then resume
        applyStimulus(2'b11, 5);
        enable_i = 1'b0;
        tick(20);
        checkOutput("frozen_filtered", int'(filtered_o), 1);
        checkOutput("frozen_rise_flags", int'(rise_flags_o), 0);
        enable_i = 1'b1;
        expectEdge(5, 2'b10, 2'b00, 2'b11);
        tick(6);
        checkOutput("resume_rise_flags", int'(rise_flags_o), 2);

        // Reset in the middle of a count with both pins high afterwards
        applyStimulus(2'b00, 4);
        reset  = 1'b1;
        pins_i = 2'b11;
        tick(1);
        checkOutput("midreset_filtered", int'(filtered_o), 0);
        checkOutput("midreset_rise", int'(rise_o), 0);
        checkOutput("midreset_fall", int'(fall_o), 0);
        checkOutput("midreset_rise_flags", int'(rise_flags_o), 0);
        checkOutput("midreset_fall_flags", int'(fall_flags_o), 0);
        checkOutput("midreset_irq", int'(irq_o), 0);
        tick(2);
        reset = 1'b0;
        expectEdge(LAT, 2'b11, 2'b00, 2'b11);
        tick(LAT + 1);
        checkOutput("post_reset_rise_flags", int'(rise_flags_o), 3);
        checkOutput("post_reset_irq", int'(irq_o), 1);

        tick(3);
        checkOutput("pending_edges", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
